// File: rtl/id_pkg.sv
// Shared decode-stage types: branch condition and immediate-extension encodings,
// plus the register-index width helper.
package id_pkg;

  typedef enum logic [2:0] {
    BR_NONE = 3'd0,
    BR_EQ   = 3'd1,
    BR_NE   = 3'd2,
    BR_LEZ  = 3'd3,
    BR_GTZ  = 3'd4,
    BR_LTZ  = 3'd5,
    BR_GEZ  = 3'd6
  } br_e;

  typedef enum logic [1:0] {
    EXT_ZERO = 2'd0,
    EXT_SIGN = 2'd1,
    EXT_LUI  = 2'd2
  } ext_e;

  function automatic int idxWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/id_fwd_mux.sv
// Operand source select for one register read port: r0, then youngest
// matching forward source, then write-back write-through, then register file.
module id_fwd_mux
  import id_pkg::*;
#(
  parameter int NFWD = 2,
  parameter int XLEN = 32,
  parameter int NREG = 32,
  localparam int RW  = idxWidth(NREG)
) (
  input  logic [RW-1:0]        idx_i,
  input  logic [NFWD-1:0]      fwd_valid_i,
  input  logic [NFWD-1:0]      fwd_pending_i,
  input  logic [NFWD*RW-1:0]   fwd_rw_i,
  input  logic [NFWD*XLEN-1:0] fwd_data_i,
  input  logic                 wb_we_i,
  input  logic [RW-1:0]        wb_rw_i,
  input  logic [XLEN-1:0]      wb_wd_i,
  input  logic [XLEN-1:0]      rf_i,
  output logic [XLEN-1:0]      value_o,
  output logic                 pending_o
);

  logic hit;

  // Pending is reported only for the winning source, so a younger ready value
  // shadows an older pending one.
  always_comb begin
    value_o   = rf_i;
    pending_o = 1'b0;
    hit       = 1'b0;
    if (idx_i == '0) begin
      value_o = '0;
    end else begin
      for (int i = 0; i < NFWD; i++) begin
        if (!hit && fwd_valid_i[i] && (fwd_rw_i[i*RW +: RW] == idx_i)) begin
          hit       = 1'b1;
          value_o   = fwd_data_i[i*XLEN +: XLEN];
          pending_o = fwd_pending_i[i];
        end
      end
      if (!hit && wb_we_i && (wb_rw_i == idx_i)) begin
        value_o = wb_wd_i;
      end
    end
  end

endmodule

// File: rtl/id_stage_gen.sv
// Decode stage: register file, operand forwarding, early branch/jump resolution
// and a valid/ready ID/EX pipeline register with load-use stall counting.
module id_stage_gen
  import id_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NREG  = 32,
  parameter int NFWD  = 2,
  parameter int CTRLW = 16,
  localparam int RW   = idxWidth(NREG)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [XLEN-1:0]      in_pcp4,
  input  logic [31:0]          in_instr,
  input  logic [2:0]           in_brtype,
  input  logic                 in_jmp,
  input  logic                 in_jr,
  input  logic [1:0]           in_extop,
  input  logic [CTRLW-1:0]     in_ctrl,
  input  logic [NFWD-1:0]      fwd_valid,
  input  logic [NFWD-1:0]      fwd_pending,
  input  logic [NFWD*RW-1:0]   fwd_rw,
  input  logic [NFWD*XLEN-1:0] fwd_data,
  input  logic                 wb_we,
  input  logic [RW-1:0]        wb_rw,
  input  logic [XLEN-1:0]      wb_wd,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      out_pcp4,
  output logic [31:0]          out_instr,
  output logic [XLEN-1:0]      out_rd1,
  output logic [XLEN-1:0]      out_rd2,
  output logic [XLEN-1:0]      out_imm,
  output logic [CTRLW-1:0]     out_ctrl,
  output logic                 redirect_valid,
  output logic [XLEN-1:0]      redirect_pc,
  output logic [31:0]          stall_cnt
);

  logic [XLEN-1:0]  rf_q [NREG];
  logic             outValid_q;
  logic [XLEN-1:0]  outPcp4_q, outRd1_q, outRd2_q, outImm_q;
  logic [31:0]      outInstr_q;
  logic [CTRLW-1:0] outCtrl_q;
  logic [31:0]      stallCnt_q, stallCnt_d;

  logic [RW-1:0]    rsIdx, rtIdx;
  logic [XLEN-1:0]  rsVal, rtVal;
  logic             rsPend, rtPend;
  logic             hazard, fire, taken;
  logic [15:0]      imm16;
  logic [XLEN-1:0]  sextImm, immExt, brTarget, jmpTarget;
  br_e              brType;
  ext_e             extOp;

  assign rsIdx   = RW'(in_instr[25:21]);
  assign rtIdx   = RW'(in_instr[20:16]);
  assign imm16   = in_instr[15:0];
  assign brType  = br_e'(in_brtype);
  assign extOp   = ext_e'(in_extop);

  id_fwd_mux #(.NFWD(NFWD), .XLEN(XLEN), .NREG(NREG)) u_fwd_rs (
    .idx_i(rsIdx), .fwd_valid_i(fwd_valid), .fwd_pending_i(fwd_pending),
    .fwd_rw_i(fwd_rw), .fwd_data_i(fwd_data), .wb_we_i(wb_we), .wb_rw_i(wb_rw),
    .wb_wd_i(wb_wd), .rf_i(rf_q[rsIdx]), .value_o(rsVal), .pending_o(rsPend)
  );

  id_fwd_mux #(.NFWD(NFWD), .XLEN(XLEN), .NREG(NREG)) u_fwd_rt (
    .idx_i(rtIdx), .fwd_valid_i(fwd_valid), .fwd_pending_i(fwd_pending),
    .fwd_rw_i(fwd_rw), .fwd_data_i(fwd_data), .wb_we_i(wb_we), .wb_rw_i(wb_rw),
    .wb_wd_i(wb_wd), .rf_i(rf_q[rtIdx]), .value_o(rtVal), .pending_o(rtPend)
  );

  assign hazard   = rsPend | rtPend;
  assign in_ready = ~hazard & (~outValid_q | out_ready);
  assign fire     = in_valid & in_ready;

  assign sextImm   = {{(XLEN-16){imm16[15]}}, imm16};
  assign brTarget  = in_pcp4 + (sextImm << 2);
  assign jmpTarget = {in_pcp4[XLEN-1:28], in_instr[25:0], 2'b00};

  always_comb begin
    immExt = {{(XLEN-16){1'b0}}, imm16};
    case (extOp)
      EXT_SIGN: immExt = sextImm;
      EXT_LUI:  immExt = {imm16, {(XLEN-16){1'b0}}};
      default:  immExt = {{(XLEN-16){1'b0}}, imm16};
    endcase
  end

  always_comb begin
    taken = 1'b0;
    case (brType)
      BR_EQ:   taken = (rsVal == rtVal);
      BR_NE:   taken = (rsVal != rtVal);
      BR_LEZ:  taken = ($signed(rsVal) <= 0);
      BR_GTZ:  taken = ($signed(rsVal) > 0);
      BR_LTZ:  taken = ($signed(rsVal) < 0);
      BR_GEZ:  taken = ($signed(rsVal) >= 0);
      default: taken = 1'b0;
    endcase
  end

  assign redirect_valid = fire & ~flush & ~rst & (in_jmp | in_jr | taken);

  always_comb begin
    redirect_pc = brTarget;
    if (in_jr)       redirect_pc = rsVal;
    else if (in_jmp) redirect_pc = jmpTarget;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else if (wb_we && (wb_rw != '0)) begin
      rf_q[wb_rw] <= wb_wd;
    end
  end

  // Flush wins over an accept in the same cycle; payload is left as-is.
  always_ff @(posedge clk) begin
    if (rst) begin
      outValid_q <= 1'b0;
      outPcp4_q  <= '0;
      outInstr_q <= '0;
      outRd1_q   <= '0;
      outRd2_q   <= '0;
      outImm_q   <= '0;
      outCtrl_q  <= '0;
    end else if (flush) begin
      outValid_q <= 1'b0;
    end else if (fire) begin
      outValid_q <= 1'b1;
      outPcp4_q  <= in_pcp4;
      outInstr_q <= in_instr;
      outRd1_q   <= rsVal;
      outRd2_q   <= rtVal;
      outImm_q   <= immExt;
      outCtrl_q  <= in_ctrl;
    end else if (out_ready) begin
      outValid_q <= 1'b0;
    end
  end

  assign stallCnt_d = (in_valid & hazard & ~flush) ? stallCnt_q + 32'd1 : stallCnt_q;

  always_ff @(posedge clk) begin
    if (rst) stallCnt_q <= '0;
    else     stallCnt_q <= stallCnt_d;
  end

  assign out_valid = outValid_q;
  assign out_pcp4  = outPcp4_q;
  assign out_instr = outInstr_q;
  assign out_rd1   = outRd1_q;
  assign out_rd2   = outRd2_q;
  assign out_imm   = outImm_q;
  assign out_ctrl  = outCtrl_q;
  assign stall_cnt = stallCnt_q;

endmodule
